pcie3_intx_requester: RTL
=========================

# pcie3_intx_requester

Legacy INTx interrupt requester for the PCIe3 configuration interrupt interface. It turns per-line level interrupt requests from user logic into the INTx_VECTOR / PENDING drive and SENT handshake that the PCIe3 core expects. It sits on the user side and connects to the core's S_PCIE3_CFG_INTERRUPT port directly or through a wirethrough stub. Only one INTx state change is in flight at a time, and every change is held until the core pulses SENT.

## Interface
- C_INTX_VECTOR_WIDTH, 4: number of INTx lines (INTA..INTD); legal values 1–4.
- C_TIMEOUT_CYCLES, 1024: maximum cycles to wait for SENT; 0 disables the timeout.

- aclk  in  1  clock; all logic is on its rising edge.
- reset  in  1  reset; synchronous, active-high.
- irq_req  in  C_INTX_VECTOR_WIDTH  level interrupt requests from user logic.
- irq_disable  in  1  Command register Interrupt Disable bit from the config space.
- err_clr  in  1  single-cycle pulse that clears timeout_err.
- m_intx_vector  out  C_INTX_VECTOR_WIDTH  INTx assert state presented to the core.
- m_sent  in  1  single-cycle pulse from the core: the Assert_INTx/Deassert_INTx message has gone out.
- m_pending  out  C_INTX_VECTOR_WIDTH  interrupt pending status to the core.
- irq_state  out  C_INTX_VECTOR_WIDTH  INTx state as confirmed by the core.
- busy  out  1  high while a change is waiting for m_sent.
- timeout_err  out  1  sticky flag: m_sent was not received in time.

## Operation
- Target state: desired = irq_req & ~{W{irq_disable}}.
- Pending: m_pending <= irq_req, registered every cycle. Pending ignores irq_disable, because PCI Interrupt Status is independent of Interrupt Disable.
- FSM states: IDLE and WAIT.
- IDLE:
  - diff = desired ^ m_intx_vector.
  - If diff is nonzero, pick idx as the first set bit of diff searching round-robin from ptr upward with wrap.
  - Toggle m_intx_vector[idx], latch idx, set ptr <= (idx+1) mod W, clear the counter, set busy <= 1, and go to WAIT.
  - An m_sent pulse in IDLE is spurious and is ignored; no state changes.
- WAIT:
  - m_intx_vector is frozen. Changes to irq_req or irq_disable are not acted on until the FSM is back in IDLE.
  - On m_sent: irq_state[idx] <= m_intx_vector[idx], busy <= 0, go to IDLE.
  - Otherwise, if C_TIMEOUT_CYCLES != 0 and counter == C_TIMEOUT_CYCLES-1: timeout_err <= 1, irq_state[idx] <= m_intx_vector[idx], busy <= 0, go to IDLE.
  - Otherwise the counter increments. Counter width is clog2(C_TIMEOUT_CYCLES+1), with a minimum of 1; it never wraps.
- Request retracted during WAIT: after SENT, IDLE sees a diff and issues the reverse change. An Assert is therefore always followed by a Deassert; no toggle is ever dropped.
- irq_disable rising: every asserted line is deasserted, one message at a time, in round-robin order. While disabled, no new assertions are made.
- timeout_err: set by a timeout; cleared by err_clr or reset. If a timeout and err_clr occur in the same cycle, the set wins.
- Reset (any state, including mid-WAIT):
  - m_intx_vector, m_pending, irq_state, busy, timeout_err, ptr and counter go to 0; FSM goes to IDLE.
  - An m_sent arriving in the cycle after reset is ignored.

## Timing
- irq_req[i] sampled high at edge N, FSM in IDLE, i selected: m_intx_vector[i] = 1 and busy = 1 after edge N. m_pending[i] = 1 after edge N.
- m_sent sampled at edge M: irq_state is updated and busy = 0 after edge M. The earliest next toggle is after edge M+1, so changes are at least 2 cycles apart.
- Timeout: the FSM leaves WAIT at edge number C_TIMEOUT_CYCLES counted from the toggle edge.
- m_sent sampled on the same edge as the toggle that starts WAIT is not matched to that change; SENT must arrive at least 1 cycle after the toggle.

## Test plan
1. Single line: irq_req = 4'b0001; core pulses m_sent 5 cycles later. m_intx_vector = 0001 and busy = 1 one cycle after the request; irq_state = 0001 after SENT. Drop irq_req, then SENT: m_intx_vector and irq_state return to 0000.
2. Round-robin: irq_req = 4'b0101 in one cycle from reset (ptr = 0). Bit 0 asserts first; bit 2 asserts only after the first SENT, 2 cycles later. A subsequent 4'b1001 request, after both are released, serves bit 3 before bit 0.
3. Disable: lines 0 and 1 are asserted and confirmed, then irq_disable = 1. Two Deassert changes occur (bit 0, then bit 1), each waiting for SENT. m_pending stays 0011 throughout.
4. Timeout: C_TIMEOUT_CYCLES = 16, no m_sent. After 16 cycles, timeout_err = 1, busy = 0 and irq_state[0] = 1. err_clr clears timeout_err.
5. Retraction: irq_req[1] pulses high for 1 cycle. m_intx_vector[1] is held until SENT, then drops, followed by a second SENT. m_pending[1] is high for exactly 1 cycle.
6. Reset mid-WAIT: reset asserted during WAIT. All outputs are 0 on the next edge; a late m_sent causes no change.

Source files
------------

// File: rtl/pcie3_intx_requester.sv
// pcie3_intx_requester
// Legacy INTx interrupt requester for the PCIe3 configuration interrupt
// interface. Per-line level requests from user logic are turned into one
// INTx assert/deassert change at a time on m_intx_vector. Each change is
// held until the core pulses m_sent, or until the optional timeout expires.
//
// Ports:
//   aclk          clock, rising edge
//   reset         synchronous, active-high reset
//   irq_req       level interrupt requests, one bit per INTx line
//   irq_disable   Command register Interrupt Disable bit
//   err_clr       single-cycle pulse clearing timeout_err
//   m_intx_vector INTx assert state presented to the core
//   m_sent        single-cycle pulse: the core has sent the INTx message
//   m_pending     registered copy of irq_req (Interrupt Status)
//   irq_state     INTx state as confirmed by the core
//   busy          a change is waiting for m_sent
//   timeout_err   sticky: m_sent did not arrive within C_TIMEOUT_CYCLES
module pcie3_intx_requester #(
  parameter int C_INTX_VECTOR_WIDTH = 4,
  parameter int C_TIMEOUT_CYCLES    = 1024
) (
  input  logic                           aclk,
  input  logic                           reset,
  input  logic [C_INTX_VECTOR_WIDTH-1:0] irq_req,
  input  logic                           irq_disable,
  input  logic                           err_clr,
  output logic [C_INTX_VECTOR_WIDTH-1:0] m_intx_vector,
  input  logic                           m_sent,
  output logic [C_INTX_VECTOR_WIDTH-1:0] m_pending,
  output logic [C_INTX_VECTOR_WIDTH-1:0] irq_state,
  output logic                           busy,
  output logic                           timeout_err
);

  localparam int W      = C_INTX_VECTOR_WIDTH;
  localparam int IW     = (W > 1) ? $clog2(W) : 1;
  localparam int CW_RAW = $clog2(C_TIMEOUT_CYCLES + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [CW-1:0] CNT_LAST = (C_TIMEOUT_CYCLES == 0) ? '0 : CW'(C_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic [0:0]    state_q,     state_d;
  logic [W-1:0]  vec_q,       vec_d;
  logic [W-1:0]  pend_q,      pend_d;
  logic [W-1:0]  irq_state_q, irq_state_d;
  logic          busy_q,      busy_d;
  logic          err_q,       err_d;
  logic [IW-1:0] ptr_q,       ptr_d;
  logic [IW-1:0] idx_q,       idx_d;
  logic [CW-1:0] cnt_q,       cnt_d;

  logic [W-1:0]  desired;
  logic [W-1:0]  diff;
  logic          found;
  logic [IW-1:0] pick;
  logic [IW-1:0] cand_idx;
  int            rr_cand;

  // Round-robin search: first line with a pending change, starting at ptr
  // and wrapping. Arithmetic is done in int so non-power-of-2 widths wrap
  // at W rather than at 2**IW.
  always_comb begin
    desired  = irq_req & ~{W{irq_disable}};
    diff     = desired ^ vec_q;
    found    = 1'b0;
    pick     = '0;
    rr_cand  = 0;
    cand_idx = '0;
    for (int k = 0; k < W; k++) begin
      rr_cand = int'(ptr_q) + k;
      if (rr_cand >= W) rr_cand = rr_cand - W;
      cand_idx = IW'(rr_cand);
      if (!found && diff[cand_idx]) begin
        found = 1'b1;
        pick  = cand_idx;
      end
    end
  end

  // NOTE: every _d starts from its _q so no path through this block leaves a
  // variable unassigned; that is what keeps synthesis from inferring latches.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    pend_d      = irq_req;  // Interrupt Status ignores Interrupt Disable
    irq_state_d = irq_state_q;
    busy_d      = busy_q;
    err_d       = err_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;

    // Cleared first so a same-cycle timeout below takes priority.
    if (err_clr) err_d = 1'b0;

    if (state_q == ST_IDLE) begin
      // m_sent here is spurious and deliberately ignored.
      if (found) begin
        vec_d[pick] = ~vec_q[pick];
        idx_d       = pick;
        ptr_d       = (int'(pick) == W - 1) ? '0 : pick + 1'b1;
        cnt_d       = '0;
        busy_d      = 1'b1;
        state_d     = ST_WAIT;
      end
    end else begin
      // vec_q is frozen while waiting; new requests wait for IDLE.
      if (m_sent) begin
        irq_state_d[idx_q] = vec_q[idx_q];
        busy_d             = 1'b0;
        state_d            = ST_IDLE;
      end else if (C_TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
        err_d              = 1'b1;
        irq_state_d[idx_q] = vec_q[idx_q];
        busy_d             = 1'b0;
        state_d            = ST_IDLE;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;  // saturates when the timeout is disabled
      end
    end
  end

  // NOTE: non-blocking assignments so every flop samples the values from
  // before this edge, independent of statement order.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      vec_q       <= '0;
      pend_q      <= '0;
      irq_state_q <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      ptr_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      pend_q      <= pend_d;
      irq_state_q <= irq_state_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
    end
  end

  assign m_intx_vector = vec_q;
  assign m_pending     = pend_q;
  assign irq_state     = irq_state_q;
  assign busy          = busy_q;
  assign timeout_err   = err_q;

endmodule
